trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Multi-cycle machine-mode trap and return sequencer for the single-cycle RISC-V core.
- Consumes the decoder's synchronous trap request (illegal instruction, ECALL), its MRET flag, and the external interrupt line.
- Owns the machine CSRs mstatus, mtvec, mepc and mcause. Stalls the datapath while it saves state, then redirects the PC to the trap vector or back to mepc.
- Sits between the control unit and the PC/next-PC logic.

Parameters:
- XLEN, 32, data/PC width
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- instr_valid  in  1  an instruction is at the execute point this cycle
- pc_cur  in  XLEN  PC of that instruction
- sync_cause  in  2  0 none, 1 illegal, 2 ecall (3 treated as illegal)
- mret  in  1  decoded MRET
- ext_int  in  1  level external interrupt
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  CSR write data
- csr_rdata  out  XLEN  combinational CSR read data
- stall  out  1  freeze PC, register file and memory writes
- kill  out  1  suppress side effects of the current instruction
- redirect_valid  out  1  load redirect_pc into the PC this cycle
- redirect_pc  out  XLEN  target PC

Behaviour:
- States:
  - IDLE: normal execution.
  - SAVE: CSR update cycle.
  - REDIRECT: vector jump.
  - RETURN: MRET jump.
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - mstatus, mepc and mcause = 0; mtvec = MTVEC_RESET.
  - All outputs 0.
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are implemented; all other bits read 0.
  - mtvec 0x305: bits[1:0] read 0 (direct mode only).
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - Unmapped addresses read 0; writes to them are ignored.
  - Software CSR writes are accepted only in IDLE with instr_valid=1 and no trap taken that cycle.
- Trap detect (IDLE, instr_valid=1):
  - take_ext = ext_int & MIE.
  - take_sync = (sync_cause != 0).
  - Priority: take_ext > take_sync > mret.
- Trap taken at cycle N:
  - Cycle N: kill=1, stall=1; latch pc_cur and the cause; next state SAVE.
  - Cycle N+1 (SAVE): stall=1.
    - mepc ← latched PC.
    - mcause ← 32'h8000_000B (external), 2 (illegal) or 11 (ecall).
    - MPIE ← MIE, MIE ← 0.
    - Next state REDIRECT.
  - Cycle N+2 (REDIRECT): stall=0, redirect_valid=1, redirect_pc = mtvec & ~3; next state IDLE.
  - Trap latency: 2 cycles from detect to redirect.
- MRET at cycle N with no trap:
  - Cycle N: kill=0, stall=1; next state RETURN.
  - Cycle N+1 (RETURN): redirect_valid=1, redirect_pc=mepc; MIE ← MPIE, MPIE ← 1; next state IDLE.
- Simultaneous events:
  - ext_int together with ECALL or illegal: the external interrupt wins, mepc = pc_cur, and the instruction is killed and re-executed after return.
  - A trap together with csr_we: the write is dropped.
  - MRET together with take_ext: the interrupt is taken and the MRET is killed.
- While not IDLE:
  - Inputs are ignored.
  - ext_int stays level-sensitive; it is re-evaluated in IDLE and is masked by the now-cleared MIE.
- instr_valid=0 in IDLE: no action, all outputs 0.
- Reset in any state: immediate return to IDLE. A partially performed SAVE is discarded, because all CSRs reset.
- redirect_valid is a single-cycle pulse. stall is never asserted in the same cycle as redirect_valid.

Decomposition:
- trap_pkg holds:
  - state enum (IDLE, SAVE, REDIRECT, RETURN).
  - CSR address constants.
  - cause codes (CAUSE_ILLEGAL=2, CAUSE_ECALL=11, CAUSE_MEXT=32'h8000_000B).
  - MIE/MPIE bit-index constants.
- Sub-module trap_csr_file holds the four CSRs with their field masking and read mux. It exposes a software write port and a trap-entry/return update port. The FSM stays in trap_sequencer.

Test Plan:
- ECALL: pc_cur=0x100, sync_cause=2, mtvec=0x200 → kill and stall at N, stall at N+1, redirect_valid with redirect_pc=0x200 at N+2; mepc=0x100, mcause=11.
- External interrupt: MIE=1, ext_int=1, pc_cur=0x40 → mcause=0x8000000B, MIE=0, MPIE=1, redirect to mtvec. With MIE=0 and ext_int=1 → no action.
- MRET: mepc=0x104, MPIE=1 → stall at N, redirect_pc=0x104 at N+1, MIE=1 afterwards.
- Priority: ext_int=1, MIE=1 and sync_cause=1 in the same cycle → mcause=0x8000000B, mepc=pc_cur. A csr_we to mtvec in the same cycle is dropped.
- CSR masking: write 0xFFFFFFFF to mtvec, mepc and mstatus → read back 0xFFFFFFFC, 0xFFFFFFFC and 0x00000088.
- Reset during SAVE → all outputs 0, state IDLE, mepc=0, mtvec=MTVEC_RESET, no redirect pulse.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer and its CSR file.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE     = 2'd1,
        REDIRECT = 2'd2,
        RETURN   = 2'd3
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_MEXT    = 32'h8000_000B;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    localparam logic [1:0] SYNC_NONE  = 2'd0;
    localparam logic [1:0] SYNC_ECALL = 2'd2;

endpackage

// File: rtl/trap_csr_file.sv
// Machine CSRs mstatus/mtvec/mepc/mcause with field masking, a software write
// port and the trap-entry / MRET update port driven by the sequencer.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_we,
    input  logic [11:0]      addr,
    input  logic [XLEN-1:0]  sw_wdata,
    input  logic             trap_save,
    input  logic [XLEN-1:0]  save_epc,
    input  logic [XLEN-1:0]  save_cause,
    input  logic             trap_return,
    output logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  mtvec,
    output logic [XLEN-1:0]  mepc,
    output logic             mie
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;

    // Next-value logic; hardware trap/return updates take precedence over software writes.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (trap_save) begin
            mepc_d   = save_epc & ALIGN_MASK;
            mcause_d = save_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (trap_return) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (sw_we) begin
            case (addr)
                CSR_MSTATUS: begin
                    mie_d  = sw_wdata[MIE_BIT];
                    mpie_d = sw_wdata[MPIE_BIT];
                end
                CSR_MTVEC:  mtvec_d  = sw_wdata & ALIGN_MASK;
                CSR_MEPC:   mepc_d   = sw_wdata & ALIGN_MASK;
                CSR_MCAUSE: mcause_d = sw_wdata;
                default:    mcause_d = mcause_q;
            endcase
        end else begin
            mie_d = mie_q;
        end
    end

    // CSR state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RESET & ALIGN_MASK;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    // Combinational read mux; unimplemented mstatus bits and unmapped addresses read zero.
    always_comb begin
        rdata = '0;
        case (addr)
            CSR_MSTATUS: begin
                rdata           = '0;
                rdata[MIE_BIT]  = mie_q;
                rdata[MPIE_BIT] = mpie_q;
            end
            CSR_MTVEC:  rdata = mtvec_q;
            CSR_MEPC:   rdata = mepc_q;
            CSR_MCAUSE: rdata = mcause_q;
            default:    rdata = '0;
        endcase
    end

    assign mtvec = mtvec_q;
    assign mepc  = mepc_q;
    assign mie   = mie_q;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: detects traps at the execute point,
// stalls while the CSRs are saved, then redirects the PC to mtvec or mepc.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [XLEN-1:0]  pc_cur,
    input  logic [1:0]       sync_cause,
    input  logic             mret,
    input  logic             ext_int,
    input  logic             csr_we,
    input  logic [11:0]      csr_addr,
    input  logic [XLEN-1:0]  csr_wdata,
    output logic [XLEN-1:0]  csr_rdata,
    output logic             stall,
    output logic             kill,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            mie_s;
    logic [XLEN-1:0] mtvec_s;
    logic [XLEN-1:0] mepc_s;
    logic            detect_s;
    logic            take_ext_s;
    logic            take_sync_s;
    logic            trap_s;
    logic            mret_go_s;
    logic            sw_we_s;

    // Event qualification at the execute point; only IDLE samples the inputs.
    always_comb begin
        detect_s    = (state_q == IDLE) && instr_valid;
        take_ext_s  = ext_int && mie_s;
        take_sync_s = (sync_cause != SYNC_NONE);
        trap_s      = detect_s && (take_ext_s || take_sync_s);
        mret_go_s   = detect_s && !trap_s && mret;
        sw_we_s     = csr_we && detect_s && !trap_s;
        stall       = trap_s || mret_go_s || (state_q == SAVE);
        kill        = trap_s;
    end

    // Next-state, trap latch and registered redirect computation.
    always_comb begin
        state_d          = state_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        case (state_q)
            IDLE: begin
                if (trap_s) begin
                    state_d = SAVE;
                    epc_d   = pc_cur;
                    if (take_ext_s) begin
                        cause_d = XLEN'(CAUSE_MEXT);
                    end else if (sync_cause == SYNC_ECALL) begin
                        cause_d = XLEN'(CAUSE_ECALL);
                    end else begin
                        cause_d = XLEN'(CAUSE_ILLEGAL);
                    end
                end else if (mret_go_s) begin
                    state_d          = RETURN;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mepc_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SAVE: begin
                state_d          = REDIRECT;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mtvec_s;
            end
            REDIRECT: state_d = IDLE;
            RETURN:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Sequencer state and registered redirect outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            epc_q            <= '0;
            cause_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            epc_q            <= epc_d;
            cause_q          <= cause_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    trap_csr_file #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk         (clk),
        .rst         (rst),
        .sw_we       (sw_we_s),
        .addr        (csr_addr),
        .sw_wdata    (csr_wdata),
        .trap_save   (state_q == SAVE),
        .save_epc    (epc_q),
        .save_cause  (cause_q),
        .trap_return (state_q == RETURN),
        .rdata       (csr_rdata),
        .mtvec       (mtvec_s),
        .mepc        (mepc_s),
        .mie         (mie_s)
    );

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed + randomized bench for trap_sequencer against a cycle-schedule reference model.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] pc_cur;
    logic [1:0]  sync_cause;
    logic        mret;
    logic        ext_int;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        kill;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(32), .MTVEC_RESET(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .pc_cur         (pc_cur),
        .sync_cause     (sync_cause),
        .mret           (mret),
        .ext_int        (ext_int),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .stall          (stall),
        .kill           (kill),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // One expected cycle: visible outputs plus the CSR effect applied at its end.
    // act: 0 none, 1 trap save, 2 mret restore, 3 software write
    typedef struct {
        bit          stall;
        bit          kill;
        bit          rv;
        logic [31:0] rpc;
        int          act;
        logic [31:0] pc;
        logic [31:0] cause;
    } cyc_t;

    cyc_t        sched[$];
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic cyc_t blank();
        cyc_t c;
        c.stall = 1'b0; c.kill = 1'b0; c.rv = 1'b0; c.rpc = 32'd0;
        c.act = 0; c.pc = 32'd0; c.cause = 32'd0;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        sched.delete();
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; pc_cur = 32'd0; sync_cause = 2'd0; mret = 1'b0;
        ext_int = 1'b0; csr_we = 1'b0; csr_addr = 12'h000; csr_wdata = 32'd0;
    endtask

    // Called just after a negedge with inputs set; checks this cycle, advances one clock.
    task automatic step();
        cyc_t cur, nxt;
        bit te, ts;
        #1;
        cur = blank();
        if (sched.size() > 0) begin
            cur = sched.pop_front();
        end else if (instr_valid) begin
            te = ext_int && m_mie;
            ts = (sync_cause != 2'd0);
            if (te || ts) begin
                cur.stall = 1'b1; cur.kill = 1'b1;
                nxt = blank();
                nxt.stall = 1'b1; nxt.act = 1; nxt.pc = pc_cur;
                nxt.cause = te ? 32'h8000_000B : ((sync_cause == 2'd2) ? 32'd11 : 32'd2);
                sched.push_back(nxt);
                nxt = blank();
                nxt.rv = 1'b1; nxt.rpc = m_mtvec;
                sched.push_back(nxt);
            end else if (mret) begin
                cur.stall = 1'b1;
                nxt = blank();
                nxt.rv = 1'b1; nxt.rpc = m_mepc; nxt.act = 2;
                sched.push_back(nxt);
            end else if (csr_we) begin
                cur.act = 3;
            end
        end
        check("stall", {31'd0, stall}, {31'd0, cur.stall});
        check("kill", {31'd0, kill}, {31'd0, cur.kill});
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, cur.rv});
        check("redirect_pc", redirect_pc, cur.rpc);
        check("csr_rdata", csr_rdata, m_read(csr_addr));
        @(posedge clk);
        case (cur.act)
            1: begin
                m_mepc = cur.pc & ~32'd3; m_mcause = cur.cause;
                m_mpie = m_mie; m_mie = 1'b0;
            end
            2: begin m_mie = m_mpie; m_mpie = 1'b1; end
            3: begin
                case (csr_addr)
                    12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h305: m_mtvec = csr_wdata & ~32'd3;
                    12'h341: m_mepc = csr_wdata & ~32'd3;
                    12'h342: m_mcause = csr_wdata;
                    default: ;
                endcase
            end
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        idle_inputs();
        instr_valid = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        step();
    endtask

    // Direct read-back against a hand-derived value.
    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        idle_inputs();
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
        step();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            step();
        end
    endtask

    logic [11:0] addr_tbl [5];

    initial begin
        addr_tbl[0] = 12'h300; addr_tbl[1] = 12'h305; addr_tbl[2] = 12'h341;
        addr_tbl[3] = 12'h342; addr_tbl[4] = 12'h7C0;
        idle_inputs();
        csr_addr = 12'h305;
        rst = 1'b0;
        model_reset();
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_kill", {31'd0, kill}, 32'd0);
        check("rst_rv", {31'd0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_mtvec", csr_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ECALL at 0x100 with mtvec 0x200
        csr_write(12'h305, 32'h0000_0200);
        idle_inputs();
        instr_valid = 1'b1; pc_cur = 32'h100; sync_cause = 2'd2;
        #1;
        check("ecall_kill_N", {31'd0, kill}, 32'd1);
        step();
        #1;
        check("ecall_stall_N1", {31'd0, stall}, 32'd1);
        idle_steps(1);
        #1;
        check("ecall_rv_N2", {31'd0, redirect_valid}, 32'd1);
        check("ecall_rpc_N2", redirect_pc, 32'h200);
        idle_steps(1);
        peek("ecall_mepc", 12'h341, 32'h100);
        peek("ecall_mcause", 12'h342, 32'd11);

        // External interrupt with MIE set
        csr_write(12'h300, 32'h0000_0008);
        idle_inputs();
        instr_valid = 1'b1; pc_cur = 32'h40; ext_int = 1'b1;
        step();
        idle_steps(2);
        peek("ext_mcause", 12'h342, 32'h8000_000B);
        peek("ext_mstatus", 12'h300, 32'h0000_0080);
        peek("ext_mepc", 12'h341, 32'h40);

        // Masked interrupt: no action
        idle_inputs();
        instr_valid = 1'b1; pc_cur = 32'h44; ext_int = 1'b1;
        #1;
        check("masked_stall", {31'd0, stall}, 32'd0);
        step();

        // MRET back to 0x104
        csr_write(12'h341, 32'h0000_0104);
        idle_inputs();
        instr_valid = 1'b1; mret = 1'b1;
        step();
        idle_inputs();
        #1;
        check("mret_rpc", redirect_pc, 32'h104);
        step();
        peek("mret_mstatus", 12'h300, 32'h0000_0088);

        // Priority: ext beats illegal, concurrent mtvec write dropped
        idle_inputs();
        instr_valid = 1'b1; pc_cur = 32'h300; ext_int = 1'b1; sync_cause = 2'd1;
        csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h999;
        step();
        idle_steps(2);
        peek("prio_mcause", 12'h342, 32'h8000_000B);
        peek("prio_mepc", 12'h341, 32'h300);
        peek("prio_mtvec", 12'h305, 32'h200);

        // Field masking
        csr_write(12'h305, 32'hFFFF_FFFF);
        csr_write(12'h341, 32'hFFFF_FFFF);
        csr_write(12'h300, 32'hFFFF_FFFF);
        csr_write(12'h7C0, 32'hFFFF_FFFF);
        peek("mask_mtvec", 12'h305, 32'hFFFF_FFFC);
        peek("mask_mepc", 12'h341, 32'hFFFF_FFFC);
        peek("mask_mstatus", 12'h300, 32'h0000_0088);
        peek("mask_unmapped", 12'h7C0, 32'd0);

        // Reset in the SAVE cycle
        idle_inputs();
        instr_valid = 1'b1; pc_cur = 32'h500; sync_cause = 2'd1;
        step();
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("srst_stall", {31'd0, stall}, 32'd0);
        check("srst_rv", {31'd0, redirect_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        peek("srst_mepc", 12'h341, 32'd0);
        peek("srst_mtvec", 12'h305, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            instr_valid = ($urandom_range(3, 0) != 0);
            pc_cur      = $urandom();
            ext_int     = ($urandom_range(7, 0) == 0);
            sync_cause  = ($urandom_range(5, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
            mret        = ($urandom_range(7, 0) == 0);
            csr_addr    = addr_tbl[$urandom_range(4, 0)];
            csr_we      = !mret && ($urandom_range(3, 0) == 0);
            csr_wdata   = $urandom();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
